// File: rtl/control_unit.sv
// Multi-cycle J17 sequencer: FETCH/DECODE/EXEC/[MEM]/WB, 4 cycles per instruction (5 for LD/ST).
// Fetch stalls one cycle per cycle of imem_ready low; HALT is absorbing until reset.
module control_unit #(
   parameter int IMEM_AW = 10
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic [31:0]        pc_in,
   input  logic               imem_ready,
   input  logic [31:0]        imem_data,
   output logic               imem_req,
   output logic [IMEM_AW-1:0] imem_addr,
   output logic [5:0]         opcode,
   output logic [3:0]         alucode,
   output logic [4:0]         op1,
   output logic [15:0]        op2,
   output logic               imControl,
   output logic               regenable,
   output logic               ramenable,
   output logic               memwrite,
   output logic [1:0]         writecode,
   output logic [1:0]         pcControl,
   output logic               busy,
   output logic               halted,
   output logic               illegal,
   output logic [31:0]        instret
);

   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_MEM    = 3'd3;
   localparam logic [2:0] S_WB     = 3'd4;
   localparam logic [2:0] S_HALT   = 3'd5;

   logic [2:0]  r_state;
   logic [2:0]  w_next;
   logic [31:0] r_ir;
   logic [31:0] r_instret;

   logic [5:0]  w_opc;
   logic        w_is_nop, w_is_alur, w_is_alui, w_is_li, w_is_ld, w_is_st;
   logic        w_is_beq, w_is_halt, w_is_legal, w_writes_reg;
   logic        w_unused;

   assign w_opc        = r_ir[31:26];
   assign w_is_nop     = (w_opc == 6'h00);
   assign w_is_alur    = (w_opc >= 6'h01) && (w_opc <= 6'h0B);
   assign w_is_alui    = (w_opc >= 6'h11) && (w_opc <= 6'h1B);
   assign w_is_li      = (w_opc == 6'h20);
   assign w_is_ld      = (w_opc == 6'h21);
   assign w_is_st      = (w_opc == 6'h22);
   assign w_is_beq     = (w_opc == 6'h30);
   assign w_is_halt    = (w_opc == 6'h3F);
   assign w_is_legal   = w_is_nop | w_is_alur | w_is_alui | w_is_li | w_is_ld |
                         w_is_st | w_is_beq | w_is_halt;
   assign w_writes_reg = w_is_alur | w_is_alui | w_is_li | w_is_ld;

   // Only the low address bits reach instruction memory.
   assign w_unused = ^pc_in[31:IMEM_AW];

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_FETCH:  if (imem_ready) w_next = S_DECODE;
         S_DECODE: w_next = w_is_halt ? S_HALT : S_EXEC;
         S_EXEC:   w_next = (w_is_ld | w_is_st) ? S_MEM : S_WB;
         S_MEM:    w_next = S_WB;
         S_WB:     w_next = S_FETCH;
         S_HALT:   w_next = S_HALT;
         default:  w_next = S_FETCH;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= S_FETCH;
         r_ir      <= 32'd0;
         r_instret <= 32'd0;
      end else begin
         r_state <= w_next;
         if (r_state == S_FETCH && imem_ready)
            r_ir <= imem_data;
         if (r_state == S_WB)
            r_instret <= r_instret + 32'd1;
      end
   end

   // Field outputs are a pure decode of IR, so they hold from DECODE through WB.
   assign opcode    = w_opc;
   assign op1       = r_ir[25:21];
   assign imControl = w_is_alui | w_is_li | w_is_ld | w_is_st;
   assign op2       = imControl ? r_ir[15:0] : {11'b0, r_ir[20:16]};
   assign alucode   = (w_is_alur | w_is_alui) ? w_opc[3:0] : 4'd0;
   assign writecode = w_is_li ? 2'd1 : (w_is_ld ? 2'd2 : 2'd0);

   assign imem_req  = (r_state == S_FETCH) && reset_n;
   assign imem_addr = pc_in[IMEM_AW-1:0];
   assign regenable = (r_state == S_WB) && w_writes_reg;
   assign ramenable = (r_state == S_MEM);
   assign memwrite  = (r_state == S_MEM) && w_is_st;
   assign pcControl = (r_state == S_WB) ? (w_is_beq ? 2'd1 : 2'd0) : 2'd3;
   assign illegal   = (r_state == S_DECODE) && !w_is_legal;
   assign halted    = (r_state == S_HALT);
   assign busy      = (r_state != S_HALT);
   assign instret   = r_instret;

endmodule

// File: tb/tb_control_unit.sv
// Directed plus randomized bench for control_unit against a per-instruction timeline model.
module tb_control_unit;

   logic        clock = 1'b0;
   logic        reset_n;
   logic [31:0] pc_in;
   logic        imem_ready;
   logic [31:0] imem_data;
   logic        imem_req;
   logic [9:0]  imem_addr;
   logic [5:0]  opcode;
   logic [3:0]  alucode;
   logic [4:0]  op1;
   logic [15:0] op2;
   logic        imControl, regenable, ramenable, memwrite;
   logic [1:0]  writecode, pcControl;
   logic        busy, halted, illegal;
   logic [31:0] instret;

   int checks = 0;
   int errors = 0;
   logic [31:0] model_instret = 32'd0;

   typedef enum {C_NOP, C_ALUR, C_ALUI, C_LI, C_LD, C_ST, C_BEQ, C_HALT, C_ILL} cls_t;
   typedef enum {P_F, P_D, P_E, P_M, P_W} ph_t;

   control_unit #(.IMEM_AW(10)) dut (
      .clock(clock), .reset_n(reset_n), .pc_in(pc_in), .imem_ready(imem_ready),
      .imem_data(imem_data), .imem_req(imem_req), .imem_addr(imem_addr),
      .opcode(opcode), .alucode(alucode), .op1(op1), .op2(op2),
      .imControl(imControl), .regenable(regenable), .ramenable(ramenable),
      .memwrite(memwrite), .writecode(writecode), .pcControl(pcControl),
      .busy(busy), .halted(halted), .illegal(illegal), .instret(instret)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic cls_t classify(input logic [5:0] op);
      if (op == 6'h00) return C_NOP;
      if (op inside {[6'h01:6'h0B]}) return C_ALUR;
      if (op inside {[6'h11:6'h1B]}) return C_ALUI;
      if (op == 6'h20) return C_LI;
      if (op == 6'h21) return C_LD;
      if (op == 6'h22) return C_ST;
      if (op == 6'h30) return C_BEQ;
      if (op == 6'h3F) return C_HALT;
      return C_ILL;
   endfunction

   task automatic check_reset(input string tag);
      chk({tag, ".imem_req"},  imem_req, 0);
      chk({tag, ".pcControl"}, pcControl, 3);
      chk({tag, ".busy"},      busy, 1);
      chk({tag, ".halted"},    halted, 0);
      chk({tag, ".regenable"}, regenable, 0);
      chk({tag, ".ramenable"}, ramenable, 0);
      chk({tag, ".memwrite"},  memwrite, 0);
      chk({tag, ".illegal"},   illegal, 0);
      chk({tag, ".opcode"},    opcode, 0);
      chk({tag, ".op2"},       op2, 0);
      chk({tag, ".fields"},    {alucode, op1, imControl, writecode}, 0);
      chk({tag, ".instret"},   instret, 0);
   endtask

   task automatic check_cycle(input ph_t ph, input logic [31:0] w, input logic [31:0] pc);
      cls_t c;
      logic imm;
      c   = classify(w[31:26]);
      imm = c inside {C_ALUI, C_LI, C_LD, C_ST};
      chk("imem_req", imem_req, ph == P_F);
      if (ph == P_F) chk("imem_addr", imem_addr, pc[9:0]);
      chk("regenable", regenable, (ph == P_W) && (c inside {C_ALUR, C_ALUI, C_LI, C_LD}));
      chk("ramenable", ramenable, ph == P_M);
      chk("memwrite",  memwrite, (ph == P_M) && (c == C_ST));
      chk("pcControl", pcControl, (ph != P_W) ? 3 : ((c == C_BEQ) ? 1 : 0));
      chk("illegal",   illegal, (ph == P_D) && (c == C_ILL));
      chk("busy",      busy, 1);
      chk("halted",    halted, 0);
      chk("instret",   instret, model_instret);
      if (ph != P_F) begin
         chk("opcode",    opcode, w[31:26]);
         chk("op1",       op1, w[25:21]);
         chk("imControl", imControl, imm);
         chk("op2",       op2, imm ? w[15:0] : {11'b0, w[20:16]});
         chk("alucode",   alucode, (c inside {C_ALUR, C_ALUI}) ? w[29:26] : 0);
         chk("writecode", writecode, (c == C_LI) ? 1 : ((c == C_LD) ? 2 : 0));
      end
   endtask

   // Starts at a negedge with the core in FETCH; ends at the negedge of the next cycle.
   task automatic run_instr(input logic [31:0] w, input int stalls, input logic [31:0] pc,
                            input int abort_c);
      cls_t c;
      int   total, idx;
      ph_t  ph;
      c     = classify(w[31:26]);
      total = stalls + 1 + ((c == C_HALT) ? 1 : ((c inside {C_LD, C_ST}) ? 4 : 3));
      pc_in = pc;
      for (int k = 1; k <= total; k++) begin
         idx = k - stalls - 1;
         if (idx <= 0)      ph = P_F;
         else if (idx == 1) ph = P_D;
         else if (idx == 2) ph = P_E;
         else if (idx == 3 && (c inside {C_LD, C_ST})) ph = P_M;
         else               ph = P_W;
         if (ph == P_F) begin
            imem_ready = (k == stalls + 1);
            imem_data  = imem_ready ? w : $urandom;
         end else begin
            imem_ready = 1'($urandom_range(0, 1));
            imem_data  = $urandom;
         end
         #1;
         check_cycle(ph, w, pc);
         if (k == abort_c) begin
            reset_n = 1'b0;
            model_instret = 32'd0;
            #1;
            check_reset("midrst");
            @(negedge clock);
            #1;
            check_reset("midrst_hold");
            @(negedge clock);
            reset_n = 1'b1;
            return;
         end
         if (ph == P_W) model_instret = model_instret + 32'd1;
         @(negedge clock);
      end
   endtask

   logic [5:0] legal_ops [10] = '{6'h00, 6'h01, 6'h05, 6'h0B, 6'h11, 6'h1B,
                                  6'h20, 6'h21, 6'h22, 6'h30};

   initial begin
      logic [5:0]  op;
      logic [31:0] r;
      reset_n    = 1'b0;
      pc_in      = 32'd5;
      imem_ready = 1'b1;
      imem_data  = 32'h0;
      repeat (3) begin
         @(negedge clock);
         #1;
         check_reset("reset");
      end
      @(negedge clock);
      reset_n = 1'b1;
      #1;
      chk("rel.imem_req", imem_req, 1);
      chk("rel.imem_addr", imem_addr, 5);

      run_instr(32'h04430000, 0, 32'd5, 0);        // ADD r2, r3
      chk("add.instret", instret, 1);
      run_instr(32'h84A00010, 2, 32'd6, 0);        // LD with two stall cycles
      run_instr(32'hC0220004, 1, 32'd7, 0);        // BEQ
      run_instr(32'h9C000000, 0, 32'd8, 0);        // opcode 0x27, illegal

      for (int i = 0; i < 40; i++) begin
         r  = $urandom;
         op = $urandom_range(0, 1) ? legal_ops[$urandom_range(0, 9)] : 6'($urandom_range(0, 62));
         run_instr({op, r[25:0]}, $urandom_range(0, 3), $urandom, 0);
      end

      run_instr(32'h88A01234, 0, 32'd40, 3);       // ST aborted by reset before MEM
      run_instr(32'h04430000, 0, 32'd41, 0);
      chk("post_rst.instret", instret, 1);

      force dut.r_instret = 32'hFFFFFFFF;
      #1;
      release dut.r_instret;
      model_instret = 32'hFFFFFFFF;
      run_instr(32'h00000000, 0, 32'd42, 0);
      chk("wrap.instret", instret, 0);

      run_instr(32'hFC000000, 0, 32'd43, 0);       // HALT
      for (int i = 0; i < 20; i++) begin
         imem_ready = 1'($urandom_range(0, 1));
         imem_data  = $urandom;
         #1;
         chk("halt.halted",    halted, 1);
         chk("halt.busy",      busy, 0);
         chk("halt.imem_req",  imem_req, 0);
         chk("halt.strobes",   {regenable, ramenable, memwrite, illegal}, 0);
         chk("halt.pcControl", pcControl, 3);
         @(negedge clock);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
